// File: rtl/aes_iterative_core.sv
// Round-iterative AES encryptor: one full round per clock on a 128-bit state, with the key
// schedule expanded on the fly from two 128-bit key registers (AES-128 or AES-256).
module aes_iterative_core #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        plaintext,
  input  logic [KEY_BITS-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        ciphertext,
  output logic                busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds until out_ready.

  localparam bit         IS256 = (KEY_BITS == 256);
  localparam logic [3:0] NR    = IS256 ? 4'd14 : 4'd10;

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_iterative_core: KEY_BITS must be 128 or 256");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, so 0 maps to 0) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte j of a block sits at [127-8j -: 8]; byte index = row + 4*column.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return t;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      t[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      t[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      t[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      t[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return t;
  endfunction

  state_e       fsm_q, fsm_d;
  logic [127:0] st_q, st_d;
  logic [127:0] ka_q, ka_d;
  logic [127:0] kb_q, kb_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;

  // 16 state lanes and 4 key lanes of S-box, all active every cycle.
  logic [127:0] sb_state;
  for (genvar i = 0; i < 16; i++) begin : g_sbox_state
    assign sb_state[127-8*i -: 8] = sbox(st_q[127-8*i -: 8]);
  end

  // AES-256 alternates RotWord+SubWord+Rcon (odd rounds) with SubWord only (even rounds).
  logic        use_rot;
  logic [31:0] last_w, rot_w, sub_w;
  assign use_rot = !IS256 || rnd_q[0];
  assign last_w  = IS256 ? kb_q[31:0] : ka_q[31:0];
  assign rot_w   = use_rot ? {last_w[23:0], last_w[31:24]} : last_w;

  for (genvar i = 0; i < 4; i++) begin : g_sbox_key
    assign sub_w[31-8*i -: 8] = sbox(rot_w[31-8*i -: 8]);
  end

  logic [31:0]  temp_w, nw0, nw1, nw2, nw3;
  logic [127:0] next_key, rk, round_out;
  always_comb begin
    temp_w    = sub_w ^ (use_rot ? {rcon_q, 24'h000000} : 32'h0);
    nw0       = ka_q[127:96] ^ temp_w;
    nw1       = ka_q[95:64] ^ nw0;
    nw2       = ka_q[63:32] ^ nw1;
    nw3       = ka_q[31:0] ^ nw2;
    next_key  = {nw0, nw1, nw2, nw3};
    rk        = IS256 ? kb_q : next_key;
    round_out = ((rnd_q == NR) ? shift_rows(sb_state) : mix_columns(shift_rows(sb_state))) ^ rk;
  end

  always_comb begin
    fsm_d     = fsm_q;
    st_d      = st_q;
    ka_d      = ka_q;
    kb_d      = kb_q;
    rnd_d     = rnd_q;
    rcon_d    = rcon_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_d   = plaintext ^ key[KEY_BITS-1 -: 128];
          ka_d   = key[KEY_BITS-1 -: 128];
          kb_d   = IS256 ? key[127:0] : 128'h0;
          rnd_d  = 4'd1;
          rcon_d = 8'h01;
          fsm_d  = S_ROUND;
        end
      end
      S_ROUND: begin
        busy  = 1'b1;
        st_d  = round_out;
        rnd_d = rnd_q + 4'd1;
        if (use_rot) rcon_d = xtime(rcon_q);
        if (IS256) begin
          ka_d = kb_q;
          kb_d = next_key;
        end else begin
          ka_d = next_key;
        end
        if (rnd_q == NR) fsm_d = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q  <= S_IDLE;
      st_q   <= '0;
      ka_q   <= '0;
      kb_q   <= '0;
      rnd_q  <= '0;
      rcon_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      st_q   <= st_d;
      ka_q   <= ka_d;
      kb_q   <= kb_d;
      rnd_q  <= rnd_d;
      rcon_q <= rcon_d;
    end
  end

  assign ciphertext = st_q;

endmodule

// File: tb/tb_aes_iterative_core.sv
// Bench for aes_iterative_core: one AES-128 and one AES-256 instance checked against FIPS-197
// vectors and a table-driven reference cipher with a fully expanded key schedule.
module tb_aes_iterative_core;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         iv_a, ir_a, ov_a, or_a, busy_a;
  logic [127:0] key_a, pt_a, ct_a;
  logic         iv_b, ir_b, ov_b, or_b, busy_b;
  logic [255:0] key_b;
  logic [127:0] pt_b, ct_b;

  aes_iterative_core #(.KEY_BITS(128)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .plaintext(pt_a), .key(key_a),
    .out_valid(ov_a), .out_ready(or_a), .ciphertext(ct_a), .busy(busy_a)
  );

  aes_iterative_core #(.KEY_BITS(256)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .plaintext(pt_b), .key(key_b),
    .out_valid(ov_b), .out_ready(or_b), .ciphertext(ct_b), .busy(busy_b)
  );

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q[$];

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] b, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      end
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Key is left-aligned in k; nk = 4 (AES-128) or 8 (AES-256).
  function automatic logic [127:0] ref_encrypt(input logic [255:0] k, input int nk,
                                               input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [31:0]  temp;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      temp = w[i-1];
      if (i % nk == 0) begin
        temp = sub_word_ref({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        temp = sub_word_ref(temp);
      end
      w[i] = w[i-nk] ^ temp;
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int j = 0; j < 16; j++) s[j] = sbox_t[s[j]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[row+4*c] = s[row+4*((c+row)%4)];
      for (int j = 0; j < 16; j++) s[j] = t[j];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- scoreboard checks ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  function automatic logic get_ov(input bit w);   return w ? ov_b : ov_a;     endfunction
  function automatic logic get_ir(input bit w);   return w ? ir_b : ir_a;     endfunction
  function automatic logic get_busy(input bit w); return w ? busy_b : busy_a; endfunction
  function automatic logic [127:0] get_ct(input bit w); return w ? ct_b : ct_a; endfunction

  task automatic drive_in(input bit w, input logic v, input logic [255:0] k,
                          input logic [127:0] p);
    if (w) begin
      iv_b = v; key_b = k; pt_b = p;
    end else begin
      iv_a = v; key_a = k[255:128]; pt_a = p;
    end
  endtask

  task automatic set_or(input bit w, input logic v);
    if (w) or_b = v;
    else   or_a = v;
  endtask

  // Called #1 after an edge with the DUT idle. lat counts rising edges from the accepting
  // edge (counted as 1) up to and including the edge after which out_valid is seen.
  task automatic run_block(input bit w, input logic [255:0] k, input logic [127:0] p,
                           output logic [127:0] got, output int lat);
    drive_in(w, 1'b1, k, p);
    @(posedge clk); #1;
    drive_in(w, 1'b0, {rand128(), rand128()}, rand128());
    chk_bit("accept_in_ready_low", get_ir(w), 1'b0);
    chk_bit("accept_busy_high", get_busy(w), 1'b1);
    lat = 1;
    while (get_ov(w) !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got = get_ct(w);
    set_or(w, 1'b1);
    @(posedge clk); #1;
    set_or(w, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [127:0] got, exp, k1, p1;
    logic [255:0] kr;
    logic [127:0] bk [4];
    logic [127:0] bp [4];
    int lat, cyc, idx, nout, last_acc, seen;
    bit acc;

    build_sbox();
    rst = 1'b1;
    drive_in(1'b0, 1'b0, '0, '0);
    drive_in(1'b1, 1'b0, '0, '0);
    or_a = 1'b0;
    or_b = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_bit("rst_in_ready_a", ir_a, 1'b1);
    chk_bit("rst_out_valid_a", ov_a, 1'b0);
    chk_bit("rst_busy_a", busy_a, 1'b0);
    chk("rst_ct_a", ct_a, 128'h0);
    chk_bit("rst_in_ready_b", ir_b, 1'b1);
    chk_bit("rst_out_valid_b", ov_b, 1'b0);
    chk_bit("rst_busy_b", busy_b, 1'b0);
    chk("rst_ct_b", ct_b, 128'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 appendix vectors
    run_block(1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
              128'h3243f6a8885a308d313198a2e0370734, got, lat);
    chk("t1_ct", got, 128'h3925841d02dc09fbdc118597196a0b32);
    chk_int("t1_latency", lat, 11);

    run_block(1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
              128'h00112233445566778899aabbccddeeff, got, lat);
    chk("t2_ct", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    run_block(1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              128'h00112233445566778899aabbccddeeff, got, lat);
    chk("t3_ct", got, 128'h8ea2b7ca516745bfeafc49904b496089);
    chk_int("t3_latency", lat, 15);

    // Backpressure: keep offering new blocks while the result is held.
    k1 = rand128();
    p1 = rand128();
    exp = ref_encrypt({k1, 128'h0}, 4, p1);
    drive_in(1'b0, 1'b1, {k1, 128'h0}, p1);
    @(posedge clk); #1;
    lat = 1;
    while (ov_a !== 1'b1 && lat < 40) begin
      drive_in(1'b0, 1'b1, {rand128(), 128'h0}, rand128());
      @(posedge clk); #1;
      lat++;
    end
    chk_int("t4_latency", lat, 11);
    for (int i = 0; i < 20; i++) begin
      drive_in(1'b0, 1'b1, {rand128(), 128'h0}, rand128());
      chk("t4_ct_held", ct_a, exp);
      chk_bit("t4_out_valid_held", ov_a, 1'b1);
      chk_bit("t4_in_ready_low", ir_a, 1'b0);
      @(posedge clk); #1;
    end
    drive_in(1'b0, 1'b0, '0, '0);
    or_a = 1'b1;
    @(posedge clk); #1;
    or_a = 1'b0;
    chk_bit("t4_release_in_ready", ir_a, 1'b1);
    chk_bit("t4_release_out_valid", ov_a, 1'b0);
    chk_bit("t4_release_busy", busy_a, 1'b0);
    k1 = rand128();
    p1 = rand128();
    run_block(1'b0, {k1, 128'h0}, p1, got, lat);
    chk("t4_next_ct", got, ref_encrypt({k1, 128'h0}, 4, p1));

    // Asynchronous reset during round 5 discards the block.
    drive_in(1'b0, 1'b1, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
             128'h3243f6a8885a308d313198a2e0370734);
    @(posedge clk); #1;
    drive_in(1'b0, 1'b0, '0, '0);
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk_bit("t5_out_valid", ov_a, 1'b0);
    chk_bit("t5_in_ready", ir_a, 1'b1);
    chk_bit("t5_busy", busy_a, 1'b0);
    chk("t5_ct_cleared", ct_a, 128'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (ov_a === 1'b1) seen++;
    end
    chk_int("t5_no_output", seen, 0);
    run_block(1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
              128'h00112233445566778899aabbccddeeff, got, lat);
    chk("t5_ct_after_reset", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // Back-to-back with in_valid and out_ready held high.
    for (int i = 0; i < 4; i++) begin
      bk[i] = rand128();
      bp[i] = rand128();
    end
    idx = 0;
    nout = 0;
    last_acc = 0;
    cyc = 0;
    or_a = 1'b1;
    drive_in(1'b0, 1'b1, {bk[0], 128'h0}, bp[0]);
    while (nout < 4 && cyc < 200) begin
      if (ov_a === 1'b1) begin
        chk_bit("t6_expected_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) chk("t6_ct", ct_a, exp_q.pop_front());
        nout++;
      end
      acc = (idx < 4) && (ir_a === 1'b1);
      if (acc) begin
        exp_q.push_back(ref_encrypt({bk[idx], 128'h0}, 4, bp[idx]));
        if (idx > 0) chk_int("t6_accept_gap", cyc - last_acc, 12);
        last_acc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 4) drive_in(1'b0, 1'b1, {bk[idx], 128'h0}, bp[idx]);
        else         drive_in(1'b0, 1'b0, '0, '0);
      end
    end
    or_a = 1'b0;
    drive_in(1'b0, 1'b0, '0, '0);
    chk_int("t6_outputs", nout, 4);
    chk_int("t6_accepts", idx, 4);
    exp_q.delete();

    // Random keys and plaintexts on both key sizes.
    for (int n = 0; n < 6; n++) begin
      kr = {rand128(), rand128()};
      p1 = rand128();
      if (n % 2 == 1) begin
        exp_q.push_back(ref_encrypt(kr, 8, p1));
        run_block(1'b1, kr, p1, got, lat);
        chk_int("t7_latency_256", lat, 15);
      end else begin
        exp_q.push_back(ref_encrypt({kr[255:128], 128'h0}, 4, p1));
        run_block(1'b0, kr, p1, got, lat);
        chk_int("t7_latency_128", lat, 11);
      end
      chk("t7_ct", got, exp_q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
